// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and write-back data/enable selection from the head entry.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [REG_AW-1:0] in_reg_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [REG_AW-1:0] out_reg_dest,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              out_wb_en,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic [REG_AW-1:0] reg_dest;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_fire;
    logic   out_fire;

    assign in_entry  = {in_reg_write, in_mem_to_reg, in_alu_result, in_mem_data, in_reg_dest};
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    head_d  = in_entry;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_d = in_entry;
                end else if (in_fire) begin
                    // Only reachable with the skid buffer; without it in_ready implies out_ready here.
                    if (SKID != 0) begin
                        state_d = TWO;
                        skid_d  = in_entry;
                    end
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            always_comb begin
                in_ready_d = (state_d != TWO);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    assign out_reg_write  = head_q.reg_write;
    assign out_mem_to_reg = head_q.mem_to_reg;
    assign out_alu_result = head_q.alu_result;
    assign out_mem_data   = head_q.mem_data;
    assign out_reg_dest   = head_q.reg_dest;
    assign out_wb_data    = head_q.mem_to_reg ? head_q.mem_data : head_q.alu_result;
    assign out_wb_en      = out_valid & head_q.reg_write & (head_q.reg_dest != '0);
    assign occupancy      = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: one instance with the skid buffer and
// one without, checked against a queue of accepted entries.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dest;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    ent_t        in_e;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic        o_rw1, o_m2r1, o_rw0, o_m2r0;
    logic [31:0] o_alu1, o_mem1, o_wbd1, o_alu0, o_mem0, o_wbd0;
    logic [4:0]  o_dest1, o_dest0;
    logic        o_wben1, o_wben0;
    logic [1:0]  o_occ1, o_occ0;
    ent_t        obs1, obs0;

    assign obs1 = {o_rw1, o_m2r1, o_alu1, o_mem1, o_dest1};
    assign obs0 = {o_rw0, o_m2r0, o_alu0, o_mem0, o_dest0};

    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .SKID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_reg_write(in_e.rw), .in_mem_to_reg(in_e.m2r),
        .in_alu_result(in_e.alu), .in_mem_data(in_e.mem), .in_reg_dest(in_e.dest),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_reg_write(o_rw1), .out_mem_to_reg(o_m2r1),
        .out_alu_result(o_alu1), .out_mem_data(o_mem1), .out_reg_dest(o_dest1),
        .out_wb_data(o_wbd1), .out_wb_en(o_wben1), .occupancy(o_occ1)
    );

    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_reg_write(in_e.rw), .in_mem_to_reg(in_e.m2r),
        .in_alu_result(in_e.alu), .in_mem_data(in_e.mem), .in_reg_dest(in_e.dest),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_reg_write(o_rw0), .out_mem_to_reg(o_m2r0),
        .out_alu_result(o_alu0), .out_mem_data(o_mem0), .out_reg_dest(o_dest0),
        .out_wb_data(o_wbd0), .out_wb_en(o_wben0), .occupancy(o_occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    ent_t        sb[$];
    logic        s_rdy, s_valid, s_wben, s_in_fire, s_out_fire;
    logic [31:0] s_wbd;
    logic [1:0]  s_occ;
    ent_t        s_obs;

    function automatic ent_t mk(input logic [31:0] alu);
        ent_t e;
        e.rw   = 1'b1;
        e.m2r  = 1'b0;
        e.alu  = alu;
        e.mem  = alu ^ 32'hFFFF_0000;
        e.dest = alu[4:0] | 5'd1;
        return e;
    endfunction

    // Drives one cycle of inputs after the falling edge, then samples the selected instance.
    task automatic drive(input bit sel, input logic iv, input ent_t e, input logic ordy, input logic fl);
        @(negedge clk);
        in_e       = e;
        flush      = fl;
        in_valid1  = sel & iv;
        out_ready1 = sel & ordy;
        in_valid0  = !sel & iv;
        out_ready0 = !sel & ordy;
        #1;
        if (sel) begin
            s_rdy = in_ready1; s_valid = out_valid1; s_obs = obs1;
            s_wbd = o_wbd1; s_wben = o_wben1; s_occ = o_occ1;
        end else begin
            s_rdy = in_ready0; s_valid = out_valid0; s_obs = obs0;
            s_wbd = o_wbd0; s_wben = o_wben0; s_occ = o_occ0;
        end
        s_in_fire  = iv & s_rdy;
        s_out_fire = s_valid & ordy;
    endtask

    task automatic test_reset();
        ent_t a, b, c;
        a = mk(32'h0000_0A01);
        b = mk(32'h0000_0B02);
        c = mk(32'h0000_0C03);
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (out_valid1 !== 1'b0 || o_occ1 !== 2'd0 || in_ready1 !== 1'b1 || o_wben1 !== 1'b0 || obs1 !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: valid=%b occ=%0d rdy=%b wben=%b obs=%h, required 0 0 1 0 0",
                     out_valid1, o_occ1, in_ready1, o_wben1, obs1);
        end
        n_checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || o_occ0 !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state_noskid: valid=%b rdy=%b occ=%0d, required 0 1 0", out_valid0, in_ready0, o_occ0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, a, 0, 0);
        drive(1, 1, b, 0, 0);
        drive(1, 0, '0, 0, 0);
        n_checks++;
        if (s_occ !== 2'd2 || s_rdy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_prefill: occ=%0d rdy=%b, required 2 0", s_occ, s_rdy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid1 !== 1'b0 || o_occ1 !== 2'd0 || in_ready1 !== 1'b1 || o_wben1 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_async: valid=%b occ=%0d rdy=%b wben=%b, required 0 0 1 0",
                     out_valid1, o_occ1, in_ready1, o_wben1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, c, 1, 0);
        n_checks++;
        if (s_valid !== 1'b0 || s_in_fire !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_first_accept: valid=%b fire=%b, required 0 1", s_valid, s_in_fire);
        end
        drive(1, 0, '0, 1, 0);
        n_checks++;
        if (s_valid !== 1'b1 || s_obs !== c) begin
            n_fail++;
            $display("[TB] FAIL reset_latency: valid=%b obs=%h, required 1 %h", s_valid, s_obs, c);
        end
    endtask

    task automatic test_streaming();
        ent_t e, exp;
        int   n_out;
        n_out = 0;
        sb.delete();
        drive(1, 0, '0, 1, 1);
        for (int k = 0; k < 10; k++) begin
            e = mk(32'h10 + 32'(k));
            drive(1, k < 8, e, 1, 0);
            n_checks++;
            if (s_rdy !== 1'b1 || s_valid !== (k >= 1 && k <= 8)) begin
                n_fail++;
                $display("[TB] FAIL stream_flow step %0d: rdy=%b valid=%b, required 1 %b", k, s_rdy, s_valid, (k >= 1 && k <= 8));
            end
            if (s_out_fire) begin
                n_checks++;
                n_out++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL stream_extra: got %h, required no output", s_obs);
                end else begin
                    exp = sb.pop_front();
                    if (s_obs !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL stream_data: got %h, required %h", s_obs, exp);
                    end
                end
            end
            if (s_in_fire) sb.push_back(e);
        end
        n_checks++;
        if (n_out != 8 || sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL stream_count: got %0d outputs, %0d left, required 8 0", n_out, sb.size());
        end
    endtask

    task automatic test_backpressure();
        bit          iv_t[8]   = '{1, 1, 1, 1, 1, 1, 0, 0};
        bit          rdy_t[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic [31:0] alu_t[8]  = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hCCCC, 32'hCCCC, 32'hCCCC, 32'h0, 32'h0};
        bit          xv_t[8]   = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic [1:0]  xocc_t[8] = '{0, 1, 2, 2, 2, 1, 1, 0};
        bit          xrdy_t[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        ent_t        e, exp;
        int          n_out;
        n_out = 0;
        sb.delete();
        drive(1, 0, '0, 1, 1);
        for (int k = 0; k < 8; k++) begin
            e = mk(alu_t[k]);
            drive(1, iv_t[k], e, rdy_t[k], 0);
            n_checks++;
            if (s_valid !== xv_t[k] || s_occ !== xocc_t[k] || s_rdy !== xrdy_t[k]) begin
                n_fail++;
                $display("[TB] FAIL bp_flow step %0d: valid=%b occ=%0d rdy=%b, required %b %0d %b",
                         k, s_valid, s_occ, s_rdy, xv_t[k], xocc_t[k], xrdy_t[k]);
            end
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (s_obs !== mk(32'hAAAA)) begin
                    n_fail++;
                    $display("[TB] FAIL bp_hold step %0d: got %h, required %h", k, s_obs, mk(32'hAAAA));
                end
            end
            if (s_out_fire) begin
                n_checks++;
                n_out++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL bp_extra: got %h, required no output", s_obs);
                end else begin
                    exp = sb.pop_front();
                    if (s_obs !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL bp_data: got %h, required %h", s_obs, exp);
                    end
                end
            end
            if (s_in_fire) sb.push_back(e);
        end
        n_checks++;
        if (n_out != 3 || sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_count: got %0d outputs, %0d left, required 3 0", n_out, sb.size());
        end
    endtask

    task automatic test_flush();
        bit          iv_t[11]  = '{1, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0};
        bit          rdy_t[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        bit          fl_t[11]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        logic [31:0] alu_t[11] = '{32'hA1, 32'hB2, 32'hC3, 32'h0, 32'hD4, 32'hE5, 32'h0, 32'h0, 32'hF6, 32'h0, 32'h0};
        bit          xv_t[11]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0};
        logic [1:0]  xocc_t[11] = '{0, 1, 2, 0, 0, 1, 0, 0, 0, 1, 0};
        ent_t        e, exp;
        int          n_out;
        n_out = 0;
        sb.delete();
        drive(1, 0, '0, 1, 1);
        for (int k = 0; k < 11; k++) begin
            e = mk(alu_t[k]);
            drive(1, iv_t[k], e, rdy_t[k], fl_t[k]);
            n_checks++;
            if (s_valid !== xv_t[k] || s_occ !== xocc_t[k] || s_wben !== xv_t[k]) begin
                n_fail++;
                $display("[TB] FAIL flush_flow step %0d: valid=%b occ=%0d wben=%b, required %b %0d %b",
                         k, s_valid, s_occ, s_wben, xv_t[k], xocc_t[k], xv_t[k]);
            end
            if (s_out_fire) begin
                n_checks++;
                n_out++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL flush_leak: got %h, required no output", s_obs);
                end else begin
                    exp = sb.pop_front();
                    if (s_obs !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL flush_data: got %h, required %h", s_obs, exp);
                    end
                end
            end
            if (fl_t[k]) sb.delete();
            else if (s_in_fire) sb.push_back(e);
        end
        n_checks++;
        if (n_out != 1 || sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL flush_count: got %0d outputs, %0d left, required 1 0", n_out, sb.size());
        end
    endtask

    task automatic test_wb_select();
        ent_t        e_t[4];
        logic [31:0] xd_t[4] = '{32'hDEADBEEF, 32'h1234, 32'h1234, 32'h5678};
        bit          xen_t[4] = '{1, 1, 0, 0};
        ent_t        exp;
        e_t[0] = '{rw: 1'b1, m2r: 1'b1, alu: 32'h1234, mem: 32'hDEADBEEF, dest: 5'd3};
        e_t[1] = '{rw: 1'b1, m2r: 1'b0, alu: 32'h1234, mem: 32'hDEADBEEF, dest: 5'd7};
        e_t[2] = '{rw: 1'b1, m2r: 1'b0, alu: 32'h1234, mem: 32'h0, dest: 5'd0};
        e_t[3] = '{rw: 1'b0, m2r: 1'b0, alu: 32'h5678, mem: 32'h0, dest: 5'd9};
        sb.delete();
        drive(1, 0, '0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            drive(1, k < 4, (k < 4) ? e_t[k] : ent_t'('0), 1, 0);
            if (k >= 1) begin
                n_checks++;
                if (s_valid !== 1'b1 || s_wbd !== xd_t[k-1] || s_wben !== xen_t[k-1]) begin
                    n_fail++;
                    $display("[TB] FAIL wb_select step %0d: valid=%b data=%h en=%b, required 1 %h %b",
                             k, s_valid, s_wbd, s_wben, xd_t[k-1], xen_t[k-1]);
                end
            end
            if (s_out_fire) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL wb_extra: got %h, required no output", s_obs);
                end else begin
                    exp = sb.pop_front();
                    if (s_obs !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL wb_data: got %h, required %h", s_obs, exp);
                    end
                end
            end
            if (s_in_fire && k < 4) sb.push_back(e_t[k]);
        end
    endtask

    task automatic test_skid0();
        bit   iv_t[5]   = '{1, 1, 1, 0, 0};
        bit   rdy_t[5]  = '{0, 0, 1, 1, 1};
        bit   xrdy_t[5] = '{1, 0, 1, 1, 1};
        bit   xv_t[5]   = '{0, 1, 1, 1, 0};
        ent_t e, exp;
        sb.delete();
        drive(0, 0, '0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            e = mk(32'h300 + 32'((k < 2) ? k : 1));
            drive(0, iv_t[k], e, rdy_t[k], 0);
            n_checks++;
            if (s_rdy !== xrdy_t[k] || s_valid !== xv_t[k] || s_occ !== 2'(xv_t[k])) begin
                n_fail++;
                $display("[TB] FAIL skid0_flow step %0d: rdy=%b valid=%b occ=%0d, required %b %b %0d",
                         k, s_rdy, s_valid, s_occ, xrdy_t[k], xv_t[k], xv_t[k]);
            end
            if (s_out_fire) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL skid0_extra: got %h, required no output", s_obs);
                end else begin
                    exp = sb.pop_front();
                    if (s_obs !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL skid0_data: got %h, required %h", s_obs, exp);
                    end
                end
            end
            if (s_in_fire) sb.push_back(e);
        end
    endtask

    task automatic test_random();
        ent_t e, exp, head, prev_obs;
        logic iv, ordy, fl, prev_hold, x_rdy;
        for (int s = 1; s >= 0; s--) begin
            bit sel;
            sel = (s == 1);
            sb.delete();
            drive(sel, 0, '0, 1, 1);
            prev_hold = 1'b0;
            prev_obs  = '0;
            for (int c = 0; c < 5000; c++) begin
                iv   = ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 2) != 0);
                fl   = ($urandom_range(0, 63) == 0);
                e    = {1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7))};
                drive(sel, iv, e, ordy, fl);
                x_rdy = sel ? (sb.size() != 2) : (ordy || sb.size() == 0);
                n_checks++;
                if (s_occ !== 2'(sb.size()) || s_valid !== (sb.size() != 0) || s_rdy !== x_rdy) begin
                    n_fail++;
                    $display("[TB] FAIL rand_flow skid=%0d cycle %0d: occ=%0d valid=%b rdy=%b, required %0d %b %b",
                             s, c, s_occ, s_valid, s_rdy, sb.size(), sb.size() != 0, x_rdy);
                end
                if (prev_hold) begin
                    n_checks++;
                    if (s_obs !== prev_obs) begin
                        n_fail++;
                        $display("[TB] FAIL rand_stable skid=%0d cycle %0d: got %h, required %h", s, c, s_obs, prev_obs);
                    end
                end
                if (sb.size() != 0) begin
                    head = sb[0];
                    n_checks++;
                    if (s_wbd !== (head.m2r ? head.mem : head.alu) || s_wben !== (head.rw && head.dest != 5'd0)) begin
                        n_fail++;
                        $display("[TB] FAIL rand_wb skid=%0d cycle %0d: data=%h en=%b, required %h %b", s, c, s_wbd, s_wben,
                                 head.m2r ? head.mem : head.alu, head.rw && head.dest != 5'd0);
                    end
                end else begin
                    n_checks++;
                    if (s_wben !== 1'b0) begin
                        n_fail++;
                        $display("[TB] FAIL rand_wb_idle skid=%0d cycle %0d: en=%b, required 0", s, c, s_wben);
                    end
                end
                if (s_out_fire) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL rand_extra skid=%0d: got %h, required no output", s, s_obs);
                    end else begin
                        exp = sb.pop_front();
                        if (s_obs !== exp) begin
                            n_fail++;
                            $display("[TB] FAIL rand_data skid=%0d cycle %0d: got %h, required %h", s, c, s_obs, exp);
                        end
                    end
                end
                if (fl) sb.delete();
                else if (s_in_fire) sb.push_back(e);
                prev_hold = s_valid & !ordy & !fl;
                prev_obs  = s_obs;
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_e       = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        in_valid0  = 1'b0;
        out_ready0 = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_wb_select();
        test_skid0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
